// File: rtl/fpu_i2f_pkg.sv
// Shared types and constants for the integer-to-float conversion sequencer.
package fpu_i2f_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        SCAN = 3'd2,
        PACK = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_e;

    localparam int BIAS_S = 127;
    localparam int BIAS_D = 1023;
    localparam int MANT_S = 23;
    localparam int MANT_D = 52;

    localparam logic [1:0]  INT_FMT_64 = 2'b11;
    localparam logic [31:0] NAN_BOX    = 32'hFFFF_FFFF;

    // Reserved and dynamic encodings fall back to round-to-nearest-even.
    function automatic rm_e legal_rm(input logic [2:0] rm);
        return (rm > 3'd4) ? RNE : rm_e'(rm);
    endfunction

endpackage

// File: rtl/fpu_i2f_round.sv
// Combinational round-and-pack stage: takes the normalised magnitude and
// produces the packed IEEE result plus the inexact flag.
module fpu_i2f_round
    import fpu_i2f_pkg::*;
(
    input  logic [63:0] m,
    input  logic [6:0]  lz,
    input  logic        sign,
    input  rm_e         rm,
    input  logic        dst_fmt,
    input  logic        zero,
    output logic [63:0] result,
    output logic        nx
);

    logic [51:0] mant;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic        carry;
    logic [10:0] expo;
    logic [10:0] expo_rnd;
    logic [52:0] mant_rnd;

    // Extract mantissa/guard/sticky for the target width, round, then pack.
    always_comb begin
        if (dst_fmt) begin
            mant   = m[62:11];
            guard  = m[10];
            sticky = |m[9:0];
            expo   = 11'(BIAS_D + 63) - {4'b0, lz};
        end else begin
            mant   = {29'b0, m[62:40]};
            guard  = m[39];
            sticky = |m[38:0];
            expo   = 11'(BIAS_S + 63) - {4'b0, lz};
        end

        case (rm)
            RNE:     inc = guard & (sticky | mant[0]);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (guard | sticky);
            RUP:     inc = !sign & (guard | sticky);
            RMM:     inc = guard;
            default: inc = 1'b0;
        endcase

        mant_rnd = {1'b0, mant} + {52'b0, inc};
        carry    = dst_fmt ? mant_rnd[52] : mant_rnd[23];
        expo_rnd = expo + {10'b0, carry};

        if (zero) begin
            result = dst_fmt ? 64'b0 : {NAN_BOX, 32'b0};
            nx     = 1'b0;
        end else begin
            if (dst_fmt)
                result = {sign, expo_rnd, carry ? 52'b0 : mant_rnd[51:0]};
            else
                result = {NAN_BOX, sign, expo_rnd[7:0], carry ? 23'b0 : mant_rnd[22:0]};
            nx = guard | sticky;
        end
    end

endmodule

// File: rtl/fpu_i2f_ctrl.sv
// Multi-cycle integer-to-float sequencer with valid/ready on both sides.
//
// state | meaning
// IDLE  | ready for a request; latches operand on handshake
// ABS   | sign extraction and magnitude (two's-complement negate)
// SCAN  | one chunk per cycle leading-zero search
// PACK  | normalise, round and register the packed result
// DONE  | result valid, held until the consumer takes it
module fpu_i2f_ctrl
    import fpu_i2f_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] int_i,
    input  logic [1:0]  int_fmt_i,
    input  logic        is_unsigned_i,
    input  logic        dst_fmt_i,
    input  logic [2:0]  rm_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] result_o,
    output logic [4:0]  fflags_o
);

    localparam int NCH = 64 / CHUNK;

    state_e      state_q, state_d;
    logic [63:0] op_q;
    logic        is64_q, uns_q, dst_q, sign_q, zero_q;
    rm_e         rm_q;
    logic [63:0] mag_q, mag0_q;
    logic [6:0]  lz_q;
    logic [3:0]  cnt_q;
    logic [63:0] result_q;
    logic [4:0]  fflags_q;

    logic              sign_abs;
    logic [63:0]       mag_abs;
    logic [31:0]       lo_abs;
    logic [CHUNK-1:0]  chunk;
    logic [6:0]        chunk_lz;
    logic [7:0]        lz_add;
    logic              last_chunk;
    logic [63:0]       rnd_result;
    logic              rnd_nx;

    assign chunk      = mag_q[63 -: CHUNK];
    assign last_chunk = (cnt_q == 4'(NCH - 1));
    assign lz_add     = {1'b0, lz_q} + 8'(CHUNK);
    assign result_o   = result_q;
    assign fflags_o   = fflags_q;

    // Sign and magnitude of the latched operand at the selected source width.
    always_comb begin
        sign_abs = !uns_q & (is64_q ? op_q[63] : op_q[31]);
        lo_abs   = sign_abs ? (~op_q[31:0] + 32'd1) : op_q[31:0];
        if (is64_q)
            mag_abs = sign_abs ? (~op_q + 64'd1) : op_q;
        else
            mag_abs = {32'b0, lo_abs};
    end

    // Leading-zero count inside the top chunk; highest set bit wins.
    always_comb begin
        chunk_lz = 7'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (chunk[i])
                chunk_lz = 7'(CHUNK - 1 - i);
        end
    end

    fpu_i2f_round u_round (
        .m       (mag0_q << lz_q),
        .lz      (lz_q),
        .sign    (sign_q),
        .rm      (rm_q),
        .dst_fmt (dst_q),
        .zero    (zero_q),
        .result  (rnd_result),
        .nx      (rnd_nx)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and handshake outputs; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = !flush_i;
                if (valid_i && !flush_i)
                    state_d = ABS;
            end
            ABS:  state_d = SCAN;
            SCAN: begin
                if ((chunk != '0) || last_chunk)
                    state_d = PACK;
            end
            PACK: state_d = DONE;
            DONE: begin
                valid_o = 1'b1;
                if (ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    // Operand capture, scan bookkeeping and result register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            is64_q   <= 1'b0;
            uns_q    <= 1'b0;
            dst_q    <= 1'b0;
            rm_q     <= RNE;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            mag_q    <= '0;
            mag0_q   <= '0;
            lz_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            fflags_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        op_q   <= int_i;
                        is64_q <= (int_fmt_i == INT_FMT_64);
                        uns_q  <= is_unsigned_i;
                        dst_q  <= dst_fmt_i;
                        rm_q   <= legal_rm(rm_i);
                    end
                end
                ABS: begin
                    sign_q <= sign_abs;
                    mag_q  <= mag_abs;
                    mag0_q <= mag_abs;
                    lz_q   <= '0;
                    cnt_q  <= '0;
                    zero_q <= 1'b0;
                end
                SCAN: begin
                    if (chunk != '0) begin
                        lz_q <= lz_q + chunk_lz;
                    end else begin
                        mag_q  <= mag_q << CHUNK;
                        lz_q   <= (lz_add > 8'd64) ? 7'd64 : lz_add[6:0];
                        cnt_q  <= cnt_q + 4'd1;
                        zero_q <= last_chunk;
                    end
                end
                PACK: begin
                    if (!flush_i) begin
                        result_q <= rnd_result;
                        fflags_q <= {4'b0, rnd_nx};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_i2f_ctrl.sv
// Directed bench for fpu_i2f_ctrl with a queue of expected results.
module tb_fpu_i2f_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [63:0] int_in;
    logic [1:0]  int_fmt;
    logic        is_uns;
    logic        dst_fmt;
    logic [2:0]  rm;
    logic        valid_out;
    logic        ready_in;
    logic [63:0] result;
    logic [4:0]  fflags;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sbq[$];

    fpu_i2f_ctrl #(.CHUNK(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .valid_i       (valid_in),
        .ready_o       (ready_out),
        .int_i         (int_in),
        .int_fmt_i     (int_fmt),
        .is_unsigned_i (is_uns),
        .dst_fmt_i     (dst_fmt),
        .rm_i          (rm),
        .valid_o       (valid_out),
        .ready_i       (ready_in),
        .result_o      (result),
        .fflags_o      (fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the handshake edge.
    task automatic drive(input logic [63:0] v, input logic [1:0] fmt, input logic uns,
                         input logic dst, input logic [2:0] r, input logic [63:0] eres,
                         input logic nx, input int lat, input string tag, input bit push);
        exp_t e;
        int_in   = v;
        int_fmt  = fmt;
        is_uns   = uns;
        dst_fmt  = dst;
        rm       = r;
        valid_in = 1'b1;
        #1;
        chk({tag, "_rdy"}, 64'(ready_out), 64'd1);
        if (push) begin
            e.res = eres;
            e.flg = {4'b0, nx};
            e.lat = lat;
            e.tag = tag;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Waits (bounded) for valid_o and compares against the oldest expectation.
    task automatic collect(output exp_t e);
        int k = 0;
        while (valid_out !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        e = sbq.pop_front();
        chk({e.tag, "_valid"}, 64'(valid_out), 64'd1);
        chk({e.tag, "_lat"}, 64'(k), 64'(e.lat));
        chk({e.tag, "_res"}, result, e.res);
        chk({e.tag, "_flg"}, 64'(fflags), 64'(e.flg));
    endtask

    task automatic consume(input string tag);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_drop"}, 64'(valid_out), 64'd0);
    endtask

    task automatic run(input logic [63:0] v, input logic [1:0] fmt, input logic uns,
                       input logic dst, input logic [2:0] r, input logic [63:0] eres,
                       input logic nx, input int lat, input string tag);
        exp_t e;
        drive(v, fmt, uns, dst, r, eres, nx, lat, tag, 1'b1);
        collect(e);
        consume(tag);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        rst_n    = 1'b0;
        flush    = 1'b0;
        valid_in = 1'b0;
        int_in   = '0;
        int_fmt  = 2'b00;
        is_uns   = 1'b0;
        dst_fmt  = 1'b0;
        rm       = 3'b000;
        ready_in = 1'b1;

        #12;
        chk("rst_valid", 64'(valid_out), 64'd0);
        chk("rst_res", result, 64'd0);
        chk("rst_flg", 64'(fflags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready_out), 64'd1);

        run(64'h1234_5678_FFFF_FFFF, 2'b00, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_BF80_0000, 1'b0, 6, "m1_s");
        run(64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 1'b1, 3'b000, 64'h43F0_0000_0000_0000, 1'b1, 3, "umax_rne");
        run(64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1, 1'b1, 3'b001, 64'h43EF_FFFF_FFFF_FFFF, 1'b1, 3, "umax_rtz");
        run(64'h0000_0000_0000_0000, 2'b00, 1'b0, 1'b0, 3'b000, 64'hFFFF_FFFF_0000_0000, 1'b0, 6, "zero");
        run(64'h0000_0000_0100_0001, 2'b11, 1'b0, 1'b0, 3'b111, 64'hFFFF_FFFF_4B80_0000, 1'b1, 5, "rm7_rne");
        run(64'hFFFF_FFFF_FEFF_FFFF, 2'b11, 1'b0, 1'b0, 3'b010, 64'hFFFF_FFFF_CB80_0001, 1'b1, 5, "neg_rdn");
        run(64'hFFFF_FFFF_FEFF_FFFF, 2'b11, 1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_CB80_0000, 1'b1, 5, "neg_rup");
        run(64'h0000_0000_0100_0003, 2'b11, 1'b1, 1'b0, 3'b000, 64'hFFFF_FFFF_4B80_0002, 1'b1, 5, "tie_even");
        run(64'h0000_0000_0100_0001, 2'b11, 1'b1, 1'b0, 3'b100, 64'hFFFF_FFFF_4B80_0001, 1'b1, 5, "tie_rmm");
        run(64'hABCD_0000_7FFF_FFFF, 2'b01, 1'b0, 1'b1, 3'b000, 64'h41DF_FFFF_FFC0_0000, 1'b0, 5, "imax_d");
        run(64'h8000_0000_0000_0000, 2'b11, 1'b0, 1'b1, 3'b000, 64'hC3E0_0000_0000_0000, 1'b0, 3, "lmin_d");

        // Backpressure: 32-bit minimum held in DONE for five cycles.
        ready_in = 1'b0;
        drive(64'h0000_0000_8000_0000, 2'b00, 1'b0, 1'b0, 3'b010, 64'hFFFF_FFFF_CF00_0000, 1'b0, 5, "imin_bp", 1'b1);
        collect(e);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 64'(valid_out), 64'd1);
            chk("bp_res", result, e.res);
            chk("bp_ready", 64'(ready_out), 64'd0);
        end
        consume("imin_bp");

        // Flush during SCAN: no result, IDLE next cycle, last result retained.
        drive(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b0, 1'b0, 3'b000, 64'h0, 1'b0, 0, "fl", 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        chk("fl_ready_lo", 64'(ready_out), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        chk("fl_ready_hi", 64'(ready_out), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            seen = seen | valid_out;
        end
        chk("fl_no_valid", 64'(seen), 64'd0);
        chk("fl_res_kept", result, 64'hFFFF_FFFF_CF00_0000);

        // Flush coinciding with a request: not accepted.
        valid_in = 1'b1;
        flush    = 1'b1;
        #1;
        chk("flv_ready", 64'(ready_out), 64'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        flush    = 1'b0;
        #1;
        chk("flv_idle", 64'(ready_out), 64'd1);
        @(posedge clk);
        #1;

        run(64'h0000_0000_0100_0003, 2'b11, 1'b1, 1'b0, 3'b000, 64'hFFFF_FFFF_4B80_0002, 1'b1, 5, "post_fl");

        // Asynchronous reset during SCAN.
        drive(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b0, 1'b0, 3'b000, 64'h0, 1'b0, 0, "ar", 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(valid_out), 64'd0);
        chk("ar_res", result, 64'd0);
        chk("ar_flg", 64'(fflags), 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_ready", 64'(ready_out), 64'd1);
        run(64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1, 1'b0, 3'b000, 64'hFFFF_FFFF_3F80_0000, 1'b0, 6, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_i2f_ctrl.md
Name: fpu_i2f_ctrl

Overview:
- Multi-cycle sequencer for integer-to-float conversion (RISC-V FCVT.S/D.W/WU/L/LU).
- Owns the normalisation datapath: magnitude/sign extraction, an iterative leading-zero scan, shift, round and pack.
- Sits behind the FPU issue port with a valid/ready handshake on both sides.
- Replaces the single-cycle, fixed-table normaliser with a bounded-latency controller that also supports flush.

Parameters:
- CHUNK, 16: bits examined per scan cycle. Legal values are 8, 16, 32 and 64.
- Number of scan chunks: NCH = 64/CHUNK.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  abort the in-flight operation
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i & ready_o
- int_i  in  64  integer operand
- int_fmt_i  in  2  2'b11 = 64-bit source; any other value = 32-bit source (uses int_i[31:0])
- is_unsigned_i  in  1  1 = unsigned source
- dst_fmt_i  in  1  0 = single, 1 = double
- rm_i  in  3  RISC-V rounding mode
- valid_o  out  1  result valid
- ready_i  in  1  result consumed when valid_o & ready_i
- result_o  out  64  packed result; single precision is NaN-boxed (upper 32 bits all ones)
- fflags_o  out  5  {NV,DZ,OF,UF,NX}; only NX is ever set

Behaviour:
- Reset: state IDLE, valid_o=0, result_o=0, fflags_o=0, scan counters 0.
- ready_o is combinational: 1 exactly when state==IDLE and flush_i==0.
- IDLE: on handshake, latch int_i, format, signedness, dst_fmt_i and rm_i, then go to ABS.
  - rm_i values 101, 110 and 111 are latched as RNE.
- ABS (1 cycle):
  - sign = !is_unsigned & (32-bit ? op[31] : op[63]).
  - mag = sign ? two's-complement negation of the source width, zero-extended to 64 bits : zero-extended operand.
  - 0x80000000 (32-bit) and 0x8000...0 (64-bit) yield magnitude 2^31 and 2^63 respectively.
  - Clear lz and chunk index c; go to SCAN.
- SCAN (1 cycle per chunk):
  - Examine mag[63:64-CHUNK].
  - Nonzero: lz += leading-zero count within the chunk, then go to PACK.
  - Zero: mag <<= CHUNK, lz += CHUNK, c += 1.
  - If c reaches NCH with no set bit, set the zero flag and go to PACK. lz saturates at 64.
- PACK (1 cycle), exponent and mantissa:
  - Normalised m = original mag << lz.
  - M = 23 for single, 52 for double. Exponent = bias + 63 - lz.
  - Kept mantissa = m[62:63-M]; guard = m[62-M]; sticky = OR of m[61-M:0].
- PACK rounding:
  - RNE: increment if guard & (sticky | lsb).
  - RTZ: never increment.
  - RDN: increment if sign & (guard|sticky).
  - RUP: increment if !sign & (guard|sticky).
  - RMM: increment if guard.
  - Mantissa carry-out increments the exponent and zeroes the mantissa. Overflow to infinity is impossible.
- PACK outputs:
  - NX = guard | sticky.
  - Zero input gives +0.0 and NX=0.
  - Register result_o and fflags_o, then go to DONE.
- DONE:
  - valid_o=1; result_o and fflags_o are held stable until ready_i.
  - On handshake: valid_o=0 next cycle, go to IDLE.
  - No new request is accepted while in DONE.
- Latency: the handshake happens in cycle 0. valid_o rises in cycle 3+c, where c is the index of the first nonzero chunk (zero input: c = NCH-1). With CHUNK=16 this is 3..6 cycles.
- flush_i:
  - In any state, the next state is IDLE and valid_o=0 next cycle; result_o keeps its last value.
  - Flush in the same cycle as valid_i: the request is not accepted (ready_o=0).
- Reset asserted mid-operation: immediate return to reset values, regardless of clock.

Decomposition:
- Package fpu_i2f_pkg:
  - state enum {IDLE, ABS, SCAN, PACK, DONE};
  - rounding-mode enum (RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100);
  - bias constants 127 and 1023; mantissa widths 23 and 52;
  - INT_FMT_64=2'b11;
  - the NaN-box constant.
- Sub-module fpu_i2f_round: purely combinational. Takes normalised m, lz, sign, rm, dst_fmt and zero; produces the packed result and NX. Used by PACK.

Test Plan:
- 32-bit signed -1 (0xFFFFFFFF), single, RNE -> result 0xFFFFFFFF_BF800000, NX=0, valid_o in cycle 6 (c=3).
- 64-bit unsigned 0xFFFFFFFF_FFFFFFFF, double, RNE -> 0x43F00000_00000000, NX=1, valid_o in cycle 3. Same with RTZ -> 0x43EFFFFF_FFFFFFFF, NX=1.
- 32-bit signed 0x80000000, single, RDN -> 0xFFFFFFFF_CF000000, NX=0, valid_o in cycle 5.
- Zero operand, 32-bit, single -> 0xFFFFFFFF_00000000, NX=0, valid_o in cycle 6. Then rm_i=3'b111 with 64-bit 0x01000001, single -> rounded as RNE to 0xFFFFFFFF_4B800000, NX=1.
- Backpressure and flush:
  - Hold ready_i=0 for 5 cycles in DONE -> result_o and valid_o stable, ready_o=0 throughout.
  - Assert flush_i during SCAN -> valid_o never rises, ready_o=1 the following cycle, and the next request converts correctly.
- Assert rst_ni low during SCAN -> valid_o, result_o and fflags_o read 0 immediately. After release, ready_o=1 and a 32-bit unsigned 1 gives 0xFFFFFFFF_3F800000.
